// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the vending datapath
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EJECT = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_FAULT = 3'd4
  } disp_state_t;

  localparam logic [5:0] COIN_UNIT   = 6'd5;
  localparam logic [5:0] MAX_PENDING = 6'd60;

  localparam logic [3:0] AMT_0  = 4'd0;
  localparam logic [3:0] AMT_5  = 4'd5;
  localparam logic [3:0] AMT_10 = 4'd10;
  localparam logic [3:0] AMT_15 = 4'd15;

  function automatic logic is_legal_amt(input logic [3:0] amt);
    return (amt == AMT_0) || (amt == AMT_5) || (amt == AMT_10) || (amt == AMT_15);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter, done when the count reaches zero
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - ejects 5-unit coins for pending change via pulse/sense hopper handshake
module change_dispenser
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 16,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       chg_valid,
  input  logic [3:0] chg_amt,
  input  logic       coin_sensed,
  output logic       coin_eject,
  output logic [5:0] pending,
  output logic [7:0] coins_out,
  output logic       busy,
  output logic       fault,
  output logic       bad_amt,
  output logic       overflow
);

  localparam int MAXC = (PULSE_CYCLES > ACK_TIMEOUT) ?
                        ((PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES) :
                        ((ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES);
  localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;

  // The timer is loaded with N-1 so that the state lasts exactly N cycles.
  localparam logic [TW-1:0] EJECT_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LOAD  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

  disp_state_t state_q, state_d;
  logic [5:0]  pending_q, pending_d;
  logic [7:0]  coins_q, coins_d;
  logic        eject_q, busy_q, fault_q, bad_q, bad_d, ovf_q, ovf_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;
  logic          dec;
  logic [5:0]    base;
  logic [6:0]    sum;

  cycle_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    dec      = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S_IDLE:  if (pending_q >= COIN_UNIT) state_d = S_EJECT;
      S_EJECT: if (tmr_done) state_d = S_WAIT;
      S_WAIT: begin
        if (coin_sensed) begin
          state_d = S_GAP;
          dec     = (pending_q >= COIN_UNIT);
        end else if (tmr_done) begin
          state_d = S_FAULT;
        end
      end
      S_GAP:   if (tmr_done) state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      tmr_load = 1'b1;
      case (state_d)
        S_EJECT: tmr_val = EJECT_LOAD;
        S_WAIT:  tmr_val = WAIT_LOAD;
        S_GAP:   tmr_val = GAP_LOAD;
        default: tmr_val = '0;
      endcase
    end
  end

  // Deposits are judged against the balance after this cycle's coin decrement.
  always_comb begin
    base      = dec ? (pending_q - COIN_UNIT) : pending_q;
    sum       = {1'b0, base} + {3'b000, chg_amt};
    pending_d = base;
    bad_d     = 1'b0;
    ovf_d     = 1'b0;
    if (chg_valid) begin
      if (!is_legal_amt(chg_amt)) begin
        bad_d = 1'b1;
      end else if (chg_amt != AMT_0) begin
        if (sum > {1'b0, MAX_PENDING}) begin
          ovf_d = 1'b1;
        end else begin
          pending_d = sum[5:0];
        end
      end
    end
    coins_d = dec ? (coins_q + 8'd1) : coins_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      coins_q   <= '0;
      eject_q   <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
      bad_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      coins_q   <= coins_d;
      eject_q   <= (state_d == S_EJECT);
      busy_q    <= (state_d != S_IDLE) || (pending_d != '0);
      fault_q   <= (state_d == S_FAULT);
      bad_q     <= bad_d;
      ovf_q     <= ovf_d;
    end
  end

  assign coin_eject = eject_q;
  assign pending    = pending_q;
  assign coins_out  = coins_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign bad_amt    = bad_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed self-checking bench for change_dispenser
module tb_change_dispenser;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       chg_valid = 1'b0;
  logic [3:0] chg_amt = 4'd0;
  logic       coin_sensed = 1'b0;
  logic       coin_eject;
  logic [5:0] pending;
  logic [7:0] coins_out;
  logic       busy, fault, bad_amt, overflow;

  int checks = 0;
  int failures = 0;

  change_dispenser dut (
    .clock       (clock),
    .reset       (reset),
    .chg_valid   (chg_valid),
    .chg_amt     (chg_amt),
    .coin_sensed (coin_sensed),
    .coin_eject  (coin_eject),
    .pending     (pending),
    .coins_out   (coins_out),
    .busy        (busy),
    .fault       (fault),
    .bad_amt     (bad_amt),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task step();
    @(posedge clock);
    #1;
  endtask

  task do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task deposit(input logic [3:0] amt);
    chg_valid = 1'b1;
    chg_amt   = amt;
    step();
    chg_valid = 1'b0;
    chg_amt   = 4'd0;
  endtask

  task wait_eject(input logic lvl, input string what);
    int n;
    n = 0;
    while (coin_eject !== lvl && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (coin_eject !== lvl) begin
      failures++;
      $display("FAIL %s: coin_eject=%b after %0d cycles, required %b", what, coin_eject, n, lvl);
    end
  endtask

  task wait_fault(input string what);
    int n;
    n = 0;
    while (fault !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL %s: fault after %0d WAIT cycles, required 16", what, n);
    end
  endtask

  task test_reset();
    do_reset();
    checks++; if (coin_eject !== 1'b0) begin failures++; $display("FAIL reset_eject: got %b want 0", coin_eject); end
    checks++; if (pending !== 6'd0) begin failures++; $display("FAIL reset_pending: got %0d want 0", pending); end
    checks++; if (coins_out !== 8'd0) begin failures++; $display("FAIL reset_coins: got %0d want 0", coins_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b want 0", fault); end
    checks++; if (bad_amt !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_pulses: got bad=%b ovf=%b want 0 0", bad_amt, overflow); end
  endtask

  task test_dispense15();
    int n;
    logic [5:0] exp_p;
    do_reset();
    deposit(4'd15);
    checks++; if (pending !== 6'd15) begin failures++; $display("FAIL dep15_pending: got %0d want 15", pending); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL dep15_busy: got %b want 1", busy); end
    checks++; if (coin_eject !== 1'b0) begin failures++; $display("FAIL dep15_eject_early: got %b want 0", coin_eject); end
    step();
    checks++; if (coin_eject !== 1'b1) begin failures++; $display("FAIL dep15_eject_latency: got %b want 1", coin_eject); end
    for (int c = 0; c < 3; c++) begin
      wait_eject(1'b1, "dep15_eject_start");
      n = 0;
      while (coin_eject === 1'b1 && n < 20) begin
        step();
        n++;
      end
      checks++; if (n !== 4) begin failures++; $display("FAIL dep15_pulse_len: coin %0d got %0d want 4", c, n); end
      coin_sensed = 1'b1;
      step();
      coin_sensed = 1'b0;
      exp_p = 6'(15 - 5 * (c + 1));
      checks++; if (pending !== exp_p) begin failures++; $display("FAIL dep15_pending_dec: got %0d want %0d", pending, exp_p); end
      checks++; if (coins_out !== 8'(c + 1)) begin failures++; $display("FAIL dep15_coins: got %0d want %0d", coins_out, c + 1); end
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL dep15_busy_gap: got %b want 1", busy); end
    step();
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dep15_busy_idle: got %b want 0", busy); end
  endtask

  task test_bad_amt();
    do_reset();
    deposit(4'd7);
    checks++; if (bad_amt !== 1'b1) begin failures++; $display("FAIL bad7_pulse: got %b want 1", bad_amt); end
    checks++; if (pending !== 6'd0) begin failures++; $display("FAIL bad7_pending: got %0d want 0", pending); end
    step();
    checks++; if (bad_amt !== 1'b0) begin failures++; $display("FAIL bad7_one_cycle: got %b want 0", bad_amt); end
    checks++; if (coin_eject !== 1'b0) begin failures++; $display("FAIL bad7_eject: got %b want 0", coin_eject); end
    deposit(4'd0);
    checks++; if (bad_amt !== 1'b0 || pending !== 6'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL zero_amt: got bad=%b pending=%0d busy=%b want 0 0 0", bad_amt, pending, busy);
    end
  endtask

  task test_overflow_fault();
    do_reset();
    for (int i = 0; i < 4; i++) deposit(4'd15);
    checks++; if (pending !== 6'd60) begin failures++; $display("FAIL ovf_fill: got %0d want 60", pending); end
    deposit(4'd5);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
    checks++; if (pending !== 6'd60) begin failures++; $display("FAIL ovf_pending: got %0d want 60", pending); end
    step();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_one_cycle: got %b want 0", overflow); end
    wait_eject(1'b0, "ovf_wait_entry");
    wait_fault("ovf_timeout");
    checks++; if (coin_eject !== 1'b0 || pending !== 6'd60) begin
      failures++; $display("FAIL ovf_fault_state: got eject=%b pending=%0d want 0 60", coin_eject, pending);
    end
  endtask

  task test_fault_deposit();
    do_reset();
    deposit(4'd5);
    wait_eject(1'b1, "flt_eject_start");
    wait_eject(1'b0, "flt_wait_entry");
    wait_fault("flt_timeout");
    step();
    checks++; if (coin_eject !== 1'b0 || fault !== 1'b1) begin
      failures++; $display("FAIL flt_hold: got eject=%b fault=%b want 0 1", coin_eject, fault);
    end
    deposit(4'd5);
    checks++; if (pending !== 6'd10) begin failures++; $display("FAIL flt_deposit: got %0d want 10", pending); end
    coin_sensed = 1'b1;
    step();
    coin_sensed = 1'b0;
    checks++; if (coins_out !== 8'd0 || pending !== 6'd10) begin
      failures++; $display("FAIL flt_sense_ignored: got coins=%0d pending=%0d want 0 10", coins_out, pending);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (fault !== 1'b0 || pending !== 6'd0 || busy !== 1'b0 || coins_out !== 8'd0) begin
      failures++; $display("FAIL flt_reset: got fault=%b pending=%0d busy=%b coins=%0d want 0 0 0 0", fault, pending, busy, coins_out);
    end
  endtask

  task test_simultaneous();
    do_reset();
    deposit(4'd10);
    wait_eject(1'b1, "sim_eject_start");
    wait_eject(1'b0, "sim_wait_entry");
    coin_sensed = 1'b1;
    chg_valid   = 1'b1;
    chg_amt     = 4'd5;
    step();
    coin_sensed = 1'b0;
    chg_valid   = 1'b0;
    chg_amt     = 4'd0;
    checks++; if (pending !== 6'd10) begin failures++; $display("FAIL sim_pending: got %0d want 10", pending); end
    checks++; if (coins_out !== 8'd1) begin failures++; $display("FAIL sim_coins: got %0d want 1", coins_out); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL sim_overflow: got %b want 0", overflow); end
  endtask

  task test_reset_mid();
    do_reset();
    deposit(4'd5);
    coin_sensed = 1'b1;
    step();
    coin_sensed = 1'b0;
    checks++; if (coins_out !== 8'd0 || pending !== 6'd5) begin
      failures++; $display("FAIL mid_idle_sense: got coins=%0d pending=%0d want 0 5", coins_out, pending);
    end
    checks++; if (coin_eject !== 1'b1) begin failures++; $display("FAIL mid_eject: got %b want 1", coin_eject); end
    coin_sensed = 1'b1;
    step();
    coin_sensed = 1'b0;
    checks++; if (coins_out !== 8'd0 || pending !== 6'd5 || coin_eject !== 1'b1) begin
      failures++; $display("FAIL mid_eject_sense: got coins=%0d pending=%0d eject=%b want 0 5 1", coins_out, pending, coin_eject);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (coin_eject !== 1'b0 || pending !== 6'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_reset: got eject=%b pending=%0d busy=%b want 0 0 0", coin_eject, pending, busy);
    end
    step();
    checks++; if (coin_eject !== 1'b0) begin failures++; $display("FAIL mid_after_reset: got %b want 0", coin_eject); end
  endtask

  initial begin
    test_reset();
    test_dispense15();
    test_bad_amt();
    test_overflow_fault();
    test_fault_deposit();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
